// File: rtl/vram_access_arbiter.sv
// rtl/vram_access_arbiter.sv - VRAM access arbiter: slot timing, refresh scheduling, in-order read tag routing
module vram_access_arbiter #(
    parameter int ACCESS_CYCLES     = 4,
    parameter int REFRESH_INTERVAL  = 640,
    parameter int REFRESH_MAX_DEFER = 2,
    parameter int TAG_DEPTH         = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        initial_busy,
    input  logic        dsp_valid,
    input  logic        cmd_valid,
    input  logic        cpu_valid,
    input  logic        dsp_write,
    input  logic        cmd_write,
    input  logic        cpu_write,
    input  logic [15:0] dsp_address,
    input  logic [15:0] cmd_address,
    input  logic [15:0] cpu_address,
    input  logic [31:0] dsp_wdata,
    input  logic [31:0] cmd_wdata,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  dsp_wdata_mask,
    input  logic [3:0]  cmd_wdata_mask,
    input  logic [3:0]  cpu_wdata_mask,
    output logic        dsp_ready,
    output logic        cmd_ready,
    output logic        cpu_ready,
    output logic        dsp_rdata_en,
    output logic        cmd_rdata_en,
    output logic        cpu_rdata_en,
    output logic [31:0] rdata,
    output logic [15:0] vram_address,
    output logic        vram_valid,
    output logic        vram_write,
    output logic        vram_refresh,
    output logic [31:0] vram_wdata,
    output logic [3:0]  vram_wdata_mask,
    input  logic [31:0] vram_rdata,
    input  logic        vram_rdata_en,
    output logic        tag_error
);

    localparam int SW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam int RW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int DW = (REFRESH_MAX_DEFER > 0) ? $clog2(REFRESH_MAX_DEFER + 1) : 1;
    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [1:0] ID_DSP = 2'd0;
    localparam logic [1:0] ID_CMD = 2'd1;
    localparam logic [1:0] ID_CPU = 2'd2;

    typedef enum logic [2:0] {
        GRANT_NONE,
        GRANT_DSP,
        GRANT_CMD,
        GRANT_CPU,
        GRANT_REF
    } grant_t;

    logic [SW-1:0] slot_cnt;
    logic [RW-1:0] refresh_cnt;
    logic [DW-1:0] defer_cnt;
    logic          refresh_pending;

    logic [1:0]    tag_mem [TAG_DEPTH];
    logic [PW-1:0] tag_wr_ptr;
    logic [PW-1:0] tag_rd_ptr;
    logic [CW-1:0] tag_count;

    logic          decision;
    logic          tag_full;
    logic          refresh_urgent;
    logic          refresh_wrap;
    logic          dsp_ok;
    logic          cmd_ok;
    logic          cpu_ok;
    grant_t        grant;
    logic          access_grant;
    logic          sel_write;
    logic [15:0]   sel_address;
    logic [31:0]   sel_wdata;
    logic [3:0]    sel_mask;
    logic [1:0]    sel_id;
    logic          tag_push;
    logic          tag_pop;
    logic [1:0]    tag_head;

    assign decision       = (slot_cnt == '0) && !initial_busy;
    assign tag_full       = (tag_count == CW'(TAG_DEPTH));
    assign refresh_urgent = refresh_pending && (defer_cnt == DW'(REFRESH_MAX_DEFER));
    assign refresh_wrap   = !initial_busy && (refresh_cnt == RW'(REFRESH_INTERVAL - 1));

    // A read cannot be granted without a free tag; writes are unaffected.
    assign dsp_ok = dsp_valid && (dsp_write || !tag_full);
    assign cmd_ok = cmd_valid && (cmd_write || !tag_full);
    assign cpu_ok = cpu_valid && (cpu_write || !tag_full);

    always_comb begin
        grant = GRANT_NONE;
        if (decision) begin
            if (refresh_urgent)       grant = GRANT_REF;
            else if (dsp_ok)          grant = GRANT_DSP;
            else if (refresh_pending) grant = GRANT_REF;
            else if (cmd_ok)          grant = GRANT_CMD;
            else if (cpu_ok)          grant = GRANT_CPU;
        end
    end

    always_comb begin
        sel_write   = 1'b0;
        sel_address = '0;
        sel_wdata   = '0;
        sel_mask    = 4'hF;
        sel_id      = ID_DSP;
        case (grant)
            GRANT_DSP: begin
                sel_write   = dsp_write;
                sel_address = dsp_address;
                sel_wdata   = dsp_wdata;
                sel_mask    = dsp_wdata_mask;
                sel_id      = ID_DSP;
            end
            GRANT_CMD: begin
                sel_write   = cmd_write;
                sel_address = cmd_address;
                sel_wdata   = cmd_wdata;
                sel_mask    = cmd_wdata_mask;
                sel_id      = ID_CMD;
            end
            GRANT_CPU: begin
                sel_write   = cpu_write;
                sel_address = cpu_address;
                sel_wdata   = cpu_wdata;
                sel_mask    = cpu_wdata_mask;
                sel_id      = ID_CPU;
            end
            default: ;
        endcase
    end

    assign access_grant = (grant == GRANT_DSP) || (grant == GRANT_CMD) || (grant == GRANT_CPU);
    assign tag_push     = access_grant && !sel_write;
    assign tag_pop      = vram_rdata_en && (tag_count != '0);
    assign tag_head     = tag_mem[tag_rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt <= '0;
        end else if (initial_busy || (slot_cnt == SW'(ACCESS_CYCLES - 1))) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + SW'(1);
        end
    end

    // A wrap coinciding with a refresh issue re-arms pending rather than losing the new request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refresh_cnt     <= '0;
            refresh_pending <= 1'b0;
            defer_cnt       <= '0;
        end else begin
            if (!initial_busy) begin
                refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + RW'(1);
            end
            if (refresh_wrap) begin
                refresh_pending <= 1'b1;
            end else if (grant == GRANT_REF) begin
                refresh_pending <= 1'b0;
            end
            if (grant == GRANT_REF) begin
                defer_cnt <= '0;
            end else if ((grant == GRANT_DSP) && refresh_pending) begin
                defer_cnt <= defer_cnt + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dsp_ready       <= 1'b0;
            cmd_ready       <= 1'b0;
            cpu_ready       <= 1'b0;
            vram_valid      <= 1'b0;
            vram_refresh    <= 1'b0;
            vram_write      <= 1'b0;
            vram_address    <= '0;
            vram_wdata      <= '0;
            vram_wdata_mask <= 4'hF;
        end else begin
            dsp_ready    <= (grant == GRANT_DSP);
            cmd_ready    <= (grant == GRANT_CMD);
            cpu_ready    <= (grant == GRANT_CPU);
            vram_valid   <= access_grant;
            vram_refresh <= (grant == GRANT_REF);
            if (access_grant) begin
                vram_write      <= sel_write;
                vram_address    <= sel_address;
                vram_wdata      <= sel_wdata;
                vram_wdata_mask <= sel_mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tag_push) begin
            tag_mem[tag_wr_ptr] <= sel_id;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_wr_ptr   <= '0;
            tag_rd_ptr   <= '0;
            tag_count    <= '0;
            tag_error    <= 1'b0;
            rdata        <= '0;
            dsp_rdata_en <= 1'b0;
            cmd_rdata_en <= 1'b0;
            cpu_rdata_en <= 1'b0;
        end else begin
            dsp_rdata_en <= tag_pop && (tag_head == ID_DSP);
            cmd_rdata_en <= tag_pop && (tag_head == ID_CMD);
            cpu_rdata_en <= tag_pop && (tag_head == ID_CPU);
            if (tag_push) begin
                tag_wr_ptr <= tag_wr_ptr + PW'(1);
            end
            if (tag_pop) begin
                tag_rd_ptr <= tag_rd_ptr + PW'(1);
                rdata      <= vram_rdata;
            end
            if (vram_rdata_en && (tag_count == '0)) begin
                tag_error <= 1'b1;
            end
            case ({tag_push, tag_pop})
                2'b10:   tag_count <= tag_count + CW'(1);
                2'b01:   tag_count <= tag_count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule
